// File: rtl/co_ctrl_pkg.sv
// co_ctrl_pkg: shared encodings for the multicycle controller and the ALU
// controller. Holds the FSM state codes, primary opcode constants, ALU-control
// opcodes, the latched opcode class, and a helper that classifies an opcode.
package co_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_RTYPE = 3'b100;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b001;

  // Instruction class captured in DECODE; CLS_NONE marks an unsupported opcode.
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_LW    = 3'd2,
    CLS_SW    = 3'd3,
    CLS_ADDI  = 3'd4,
    CLS_SLTI  = 3'd5,
    CLS_BEQ   = 3'd6,
    CLS_J     = 3'd7
  } op_class_e;

  function automatic op_class_e classify(input logic [5:0] op);
    case (op)
      OP_RTYPE: classify = CLS_RTYPE;
      OP_LW:    classify = CLS_LW;
      OP_SW:    classify = CLS_SW;
      OP_ADDI:  classify = CLS_ADDI;
      OP_SLTI:  classify = CLS_SLTI;
      OP_BEQ:   classify = CLS_BEQ;
      OP_J:     classify = CLS_J;
      default:  classify = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: Moore-style multicycle datapath controller.
// Ports:
//   clk_i, rst_i (async active-low)      - clock and reset
//   op_i[5:0], mem_ready_i               - opcode field, memory handshake
//   alu_op_o[2:0], alu_src_a_o, alu_src_b_o[1:0] - ALU operand/op selects
//   pc_write_o, pc_write_cond_o, pc_source_o[1:0] - PC update controls
//   iord_o, mem_read_o, mem_write_o, ir_write_o   - memory/IR controls
//   reg_write_o, reg_dst_o, mem_to_reg_o          - register file controls
//   state_o[3:0], illegal_o                       - status
module alu_seq_ctrl
  import co_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output logic [2:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic [1:0] pc_source_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  state_e    state_q;
  op_class_e class_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      class_q <= CLS_NONE;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_ready_i) state_q <= S_DECODE;
        S_DECODE: begin
          class_q <= classify(op_i);
          case (classify(op_i))
            CLS_RTYPE:         state_q <= S_EXEC_R;
            CLS_LW, CLS_SW:    state_q <= S_MEM_ADDR;
            CLS_ADDI, CLS_SLTI: state_q <= S_EXEC_I;
            CLS_BEQ:           state_q <= S_BRANCH;
            CLS_J:             state_q <= S_JUMP;
            default:           state_q <= S_HALT;
          endcase
        end
        // lw/sw split uses the latched class so op_i may change after DECODE.
        S_MEM_ADDR: state_q <= (class_q == CLS_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready_i) state_q <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready_i) state_q <= S_FETCH;
        S_EXEC_R:   state_q <= S_R_WB;
        S_EXEC_I:   state_q <= S_I_WB;
        S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_q <= S_FETCH;
        default:    state_q <= S_HALT;
      endcase
    end
  end

  // Output decode from the state register only (FETCH additionally qualifies
  // its IR/PC write strobes with the memory handshake). Because it is decoded
  // from state_q, outputs show the FETCH decode throughout reset.
  always_comb begin
    alu_op_o        = ALU_ADD;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    pc_source_o     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE:   alu_src_b_o = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_RTYPE;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = (class_q == CLS_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB:     reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'b01;
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b10;
      end
      default: ;
    endcase
  end

  assign state_o   = state_q;
  // HALT is only reachable through an unsupported opcode and is left only by
  // reset, so the flag is sticky without a separate register.
  assign illegal_o = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i;
  logic       mem_ready_i;
  logic [2:0] alu_op_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o;
  logic       ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o;
  logic [1:0] pc_source_o;
  logic [3:0] state_o;
  logic       illegal_o;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .mem_ready_i(mem_ready_i),
    .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .pc_source_o(pc_source_o), .state_o(state_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; op_i = 6'b000000; mem_ready_i = 1'b1;
    #3;
    // Reset: FETCH decode visible during reset
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_illegal", 8'(illegal_o), 8'd0);
    chk("rst_mem_read", 8'(mem_read_o), 8'd1);
    chk("rst_ir_write", 8'(ir_write_o), 8'd1);
    chk("rst_src_b", 8'(alu_src_b_o), 8'd1);
    chk("rst_alu_op", 8'(alu_op_o), 8'b010);
    chk("rst_reg_write", 8'(reg_write_o), 8'd0);
    @(negedge clk_i); rst_i = 1'b1;

    // R-type: 0,1,6,7,0
    tick; chk("r_decode", 8'(state_o), 8'd1);
    chk("r_dec_src_b", 8'(alu_src_b_o), 8'd3);
    tick; chk("r_exec", 8'(state_o), 8'd6);
    chk("r_exec_alu_op", 8'(alu_op_o), 8'b100);
    chk("r_exec_src_a", 8'(alu_src_a_o), 8'd1);
    chk("r_exec_regw", 8'(reg_write_o), 8'd0);
    tick; chk("r_wb", 8'(state_o), 8'd7);
    chk("r_wb_regw", 8'(reg_write_o), 8'd1);
    chk("r_wb_regdst", 8'(reg_dst_o), 8'd1);
    tick; chk("r_fetch", 8'(state_o), 8'd0);
    chk("r_fetch_regw", 8'(reg_write_o), 8'd0);

    // lw with 3 wait cycles in MEM_RD
    op_i = 6'b100011;
    tick; chk("lw_decode", 8'(state_o), 8'd1);
    tick; chk("lw_addr", 8'(state_o), 8'd2);
    chk("lw_addr_src_b", 8'(alu_src_b_o), 8'd2);
    mem_ready_i = 1'b0;
    tick; chk("lw_rd0", 8'(state_o), 8'd3);
    chk("lw_rd_iord", 8'(iord_o), 8'd1);
    chk("lw_rd_memrd", 8'(mem_read_o), 8'd1);
    tick; chk("lw_rd1", 8'(state_o), 8'd3);
    tick; chk("lw_rd2", 8'(state_o), 8'd3);
    tick; chk("lw_rd3", 8'(state_o), 8'd3);
    mem_ready_i = 1'b1;
    tick; chk("lw_wb", 8'(state_o), 8'd4);
    chk("lw_wb_m2r", 8'(mem_to_reg_o), 8'd1);
    chk("lw_wb_regw", 8'(reg_write_o), 8'd1);
    chk("lw_wb_regdst", 8'(reg_dst_o), 8'd0);
    tick; chk("lw_fetch", 8'(state_o), 8'd0);

    // slti: latched class keeps alu_op at slt
    op_i = 6'b001010;
    tick; tick; chk("slti_exec", 8'(state_o), 8'd8);
    chk("slti_alu_op", 8'(alu_op_o), 8'b001);
    op_i = 6'b001000; #1;
    chk("slti_alu_op_hold", 8'(alu_op_o), 8'b001);
    tick; chk("slti_wb", 8'(state_o), 8'd9);
    chk("slti_wb_regw", 8'(reg_write_o), 8'd1);
    tick; chk("slti_fetch", 8'(state_o), 8'd0);

    // addi drives add
    tick; tick; chk("addi_alu_op", 8'(alu_op_o), 8'b010);
    tick; tick; chk("addi_fetch", 8'(state_o), 8'd0);

    // beq: 3-cycle return
    op_i = 6'b000100;
    tick; tick; chk("beq_state", 8'(state_o), 8'd10);
    chk("beq_alu_op", 8'(alu_op_o), 8'b011);
    chk("beq_pwc", 8'(pc_write_cond_o), 8'd1);
    chk("beq_pcsrc", 8'(pc_source_o), 8'd1);
    tick; chk("beq_fetch", 8'(state_o), 8'd0);

    // j
    op_i = 6'b000010;
    tick; tick; chk("j_state", 8'(state_o), 8'd11);
    chk("j_pcw", 8'(pc_write_o), 8'd1);
    chk("j_pcsrc", 8'(pc_source_o), 8'd2);
    tick; chk("j_fetch", 8'(state_o), 8'd0);

    // sw, then async reset mid MEM_WR
    op_i = 6'b101011;
    tick; tick; chk("sw_addr", 8'(state_o), 8'd2);
    mem_ready_i = 1'b0;
    tick; chk("sw_wr", 8'(state_o), 8'd5);
    chk("sw_memw", 8'(mem_write_o), 8'd1);
    chk("sw_memrd", 8'(mem_read_o), 8'd0);
    tick; chk("sw_wr_hold", 8'(state_o), 8'd5);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_state", 8'(state_o), 8'd0);
    chk("arst_memw", 8'(mem_write_o), 8'd0);
    rst_i = 1'b1;
    // FETCH holds while memory not ready; no IR write
    tick; chk("fetch_wait", 8'(state_o), 8'd0);
    chk("fetch_wait_irw", 8'(ir_write_o), 8'd0);
    mem_ready_i = 1'b1;

    // Illegal opcode -> HALT, sticky
    op_i = 6'b111111;
    tick; tick; chk("halt_state", 8'(state_o), 8'd12);
    chk("halt_illegal", 8'(illegal_o), 8'd1);
    chk("halt_memrd", 8'(mem_read_o), 8'd0);
    op_i = 6'b000000;
    tick; tick; chk("halt_sticky", 8'(state_o), 8'd12);
    chk("halt_illegal_sticky", 8'(illegal_o), 8'd1);
    rst_i = 1'b0; #1;
    chk("halt_rst_illegal", 8'(illegal_o), 8'd0);
    chk("halt_rst_state", 8'(state_o), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
